// File: rtl/e203_exu_bjp_rslv_pkg.sv
`default_nettype none
// ============================================================================
// Module  : e203_exu_bjp_rslv_pkg
// Purpose : Shared core widths and sequential-PC step sizes for branch resolve.
// Revision: 1.0 - initial release
// ============================================================================
package e203_exu_bjp_rslv_pkg;
    localparam int E203_PC_SIZE = 32;
    localparam int E203_XLEN    = 32;
    localparam int c_STEP_RV32  = 4;
    localparam int c_STEP_RV16  = 2;
endpackage
`default_nettype wire

// File: rtl/e203_exu_bjp_rslv_if.sv
`default_nettype none
// ============================================================================
// Module  : e203_exu_bjp_rslv_if
// Purpose : Commit beat and IFU flush request bundle for the branch resolver.
// Revision: 1.0 - initial release
// ============================================================================
interface e203_exu_bjp_rslv_if
    import e203_exu_bjp_rslv_pkg::*;
#(
    parameter int PC_SIZE = E203_PC_SIZE,
    parameter int XLEN    = E203_XLEN
);
    logic               cmt_i_valid;
    logic               cmt_i_ready;
    logic               cmt_i_bjp;
    logic               cmt_i_prdt_taken;
    logic               cmt_i_rslv_taken;
    logic               cmt_i_rv32;
    logic [PC_SIZE-1:0] cmt_i_pc;
    logic [XLEN-1:0]    cmt_i_imm;
    logic               flush_req;
    logic               flush_ack;
    logic [PC_SIZE-1:0] flush_add_op1;
    logic [PC_SIZE-1:0] flush_add_op2;

    modport master (
        output cmt_i_valid, cmt_i_bjp, cmt_i_prdt_taken, cmt_i_rslv_taken,
               cmt_i_rv32, cmt_i_pc, cmt_i_imm, flush_ack,
        input  cmt_i_ready, flush_req, flush_add_op1, flush_add_op2
    );

    modport slave (
        input  cmt_i_valid, cmt_i_bjp, cmt_i_prdt_taken, cmt_i_rslv_taken,
               cmt_i_rv32, cmt_i_pc, cmt_i_imm, flush_ack,
        output cmt_i_ready, flush_req, flush_add_op1, flush_add_op2
    );
endinterface
`default_nettype wire

// File: rtl/e203_exu_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module  : e203_exu_sat_cnt
// Purpose : Saturating up-counter with a clear that overrides increment.
// Revision: 1.0 - initial release
// ============================================================================
module e203_exu_sat_cnt #(
    parameter int CNT_W = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             inc,
    input  wire logic             clr,
    output logic      [CNT_W-1:0] cnt
);
    logic [CNT_W-1:0] r_cnt;
    logic             w_max;

    assign w_max = &r_cnt;
    assign cnt   = r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && !w_max) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/e203_exu_bjp_rslv.sv
`default_nettype none
// ============================================================================
// Module  : e203_exu_bjp_rslv
// Purpose : Flags committed branch mispredicts to the IFU and counts branches.
// Revision: 1.0 - initial release
// ============================================================================
module e203_exu_bjp_rslv
    import e203_exu_bjp_rslv_pkg::*;
#(
    parameter int PC_SIZE = E203_PC_SIZE,
    parameter int XLEN    = E203_XLEN,
    parameter int CNT_W   = 32
) (
    input  wire logic               clk,
    input  wire logic               rst,
    e203_exu_bjp_rslv_if.slave      bus,
    input  wire logic               cnt_clr,
    output logic      [CNT_W-1:0]   cnt_bjp,
    output logic      [CNT_W-1:0]   cnt_mispred
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PEND = 1'b1;

    localparam logic [PC_SIZE-1:0] c_OP2_RV32 = PC_SIZE'(c_STEP_RV32);
    localparam logic [PC_SIZE-1:0] c_OP2_RV16 = PC_SIZE'(c_STEP_RV16);

    logic [0:0]         r_state;
    logic [0:0]         w_nxt_state;
    logic               w_acc;
    logic               w_mis;
    logic [XLEN-1:0]    w_imm;
    logic [PC_SIZE-1:0] r_op1;
    logic [PC_SIZE-1:0] r_op2;

    assign w_imm = bus.cmt_i_imm;
    assign w_acc = bus.cmt_i_valid && (r_state == IDLE);
    assign w_mis = w_acc && bus.cmt_i_bjp
                   && (bus.cmt_i_prdt_taken != bus.cmt_i_rslv_taken);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            IDLE:    if (w_mis) w_nxt_state = PEND;
            PEND:    if (bus.flush_ack) w_nxt_state = IDLE;
            default: w_nxt_state = IDLE;
        endcase
    end

    // Predicted-taken but fell through: redirect to the sequential PC;
    // otherwise the IFU missed a taken branch and needs pc+imm.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op1 <= '0;
            r_op2 <= '0;
        end else if (w_mis) begin
            r_op1 <= bus.cmt_i_pc;
            if (bus.cmt_i_prdt_taken) begin
                r_op2 <= bus.cmt_i_rv32 ? c_OP2_RV32 : c_OP2_RV16;
            end else begin
                r_op2 <= w_imm[PC_SIZE-1:0];
            end
        end
    end

    assign bus.cmt_i_ready   = (r_state == IDLE);
    assign bus.flush_req     = (r_state == PEND);
    assign bus.flush_add_op1 = r_op1;
    assign bus.flush_add_op2 = r_op2;

    e203_exu_sat_cnt #(.CNT_W(CNT_W)) u_cnt_bjp (
        .clk (clk),
        .rst (rst),
        .inc (w_acc && bus.cmt_i_bjp),
        .clr (cnt_clr),
        .cnt (cnt_bjp)
    );

    e203_exu_sat_cnt #(.CNT_W(CNT_W)) u_cnt_mispred (
        .clk (clk),
        .rst (rst),
        .inc (w_mis),
        .clr (cnt_clr),
        .cnt (cnt_mispred)
    );
endmodule
`default_nettype wire
